fb_pixel_loader: RTL and testbench
==================================

Name: fb_pixel_loader

Overview:
- Upstream write stage for the 200x150, 3-bit-per-pixel framebuffer that the VGA scan-out stage reads.
- Replaces the direct negedge-of-pin write with a design that runs entirely in the pixel clock domain.
- Synchronises an external host strobe/data bus, decodes pixel-write and command transfers, and drives a single-cycle framebuffer write port.
- Includes a hardware clear-screen fill engine.

Parameters:
- H_PIXELS, 200, active pixels per line.
- V_PIXELS, 150, active lines (framebuffer rows).
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS.
- DATA_W, 3, pixel width; bit0=red, bit1=green, bit2=blue.
- SYNC_STAGES, 2, synchroniser depth on all host inputs (>=2).

Ports:
- clk_10mhz  in  1  pixel clock from the PLL; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- strobe_n_async  in  1  host transfer strobe; idle high; one transfer per falling edge.
- sel_async  in  1  host transfer type: 0=pixel, 1=command.
- data_async  in  DATA_W  host pixel colour or command code.
- fb_we  out  1  framebuffer write enable, one cycle per write.
- fb_addr  out  ADDR_W  framebuffer write address (row*H_PIXELS+col).
- fb_wdata  out  DATA_W  framebuffer write data.
- busy  out  1  fill in progress; host transfers are dropped while high.
- overrun  out  1  sticky: a transfer was dropped.

Behaviour:
- Reset (async assert, sync deassert):
  - fb_we=0, fb_addr=0, fb_wdata=0, busy=0, overrun=0.
  - cursor=0, fill_colour=0, state=IDLE.
  - strobe synchroniser flops reset to 1 (no false edge after reset); sel/data synchroniser flops reset to 0.
- Synchronisation: strobe, sel and data each pass through SYNC_STAGES flops. An event is detected when the synchronised strobe was 1 last cycle and is 0 this cycle. sel/data are sampled in the event cycle.
- Host timing: sel/data stable >= SYNC_STAGES+1 clocks before and after the strobe falling edge; strobe low and high each >= SYNC_STAGES+1 clocks.
- Latency: strobe falling edge at pin -> fb_we high is SYNC_STAGES+1 clocks (3 at default). Outputs are registered.
- State IDLE, pixel event (sel=0):
  - Next cycle: fb_we=1, fb_addr=cursor, fb_wdata=data.
  - fill_colour<=data.
  - cursor<=cursor+1, wrapping from H_PIXELS*V_PIXELS-1 (29999) to 0.
- State IDLE, command event (sel=1), by data:
  - 000 HOME: cursor<=0; no write.
  - 001 FILL: go to FILL.
  - 010 CLR_OVR: overrun<=0.
  - 011 and 1xx: reserved; ignored with no state change.
- State FILL:
  - The cycle after the FILL event: busy=1, fb_we=1, fb_addr=0, fb_wdata=fill_colour.
  - fb_addr increments by 1 each clock up to 29999, giving 30000 consecutive write cycles.
  - The cycle after the last write: fb_we=0, busy=0, cursor=0, state=IDLE.
- Any event while in FILL: dropped and overrun<=1, including CLR_OVR. overrun holds until a CLR_OVR is accepted in IDLE.
- fb_we=0 in every cycle with no write. fb_addr/fb_wdata hold their last values when fb_we=0.
- Address arithmetic is unsigned ADDR_W-bit. fb_addr never exceeds H_PIXELS*V_PIXELS-1.
- Reset asserted mid-fill: outputs go to reset values immediately; the fill is abandoned and not resumed.
- A strobe edge coincident with reset deassertion is not detected, because the strobe synchroniser resets to 1.

Decomposition:
- Package fb_pkg:
  - FB_H_PIXELS, FB_V_PIXELS, FB_PIXELS (=30000), FB_ADDR_W, FB_DATA_W.
  - pixel_t (DATA_W bits), fb_addr_t.
  - Command codes CMD_HOME, CMD_FILL, CMD_CLR_OVR.
  - Loader state enum {IDLE, FILL}.
- The VGA scan-out stage imports the same package constants.
- One sub-module: input_sync. It is a parameterised SYNC_STAGES synchroniser with reset value per bit, plus falling-edge detect on the strobe. It is instantiated once for the strobe and once for the sel/data bus.

Test Plan:
- Reset, then 3 pixel strobes with data 111, 010, 001 -> three single-cycle fb_we pulses, each 3 clocks after its pin falling edge; (addr,data) = (0,111), (1,010), (2,001).
- 30001 pixel strobes with data 100 -> addresses 0..29999, then the 30001st write at addr 0 (wrap); fb_addr never reaches 30000.
- Write 5 pixels, then HOME, then pixel 011 -> that write lands at addr 0; HOME itself produces no fb_we.
- Pixel 101, then FILL -> busy high for exactly 30000 cycles; fb_we high on the same cycles with addr 0..29999 and wdata 101; next pixel lands at addr 0.
- Pixel strobe during FILL -> no extra write, fill continues to 29999, overrun=1. CLR_OVR during FILL leaves overrun=1; CLR_OVR after FILL clears it to 0.
- Assert resetn low at fill address ~1000 -> fb_we/busy drop to 0 with no clock edge needed; after release, the first pixel writes addr 0 with fill_colour reset to 000.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_pkg                                                                     |
// | Shared framebuffer geometry, pixel/address types and loader command codes. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fb_pkg;

  localparam int FB_H_PIXELS = 200;
  localparam int FB_V_PIXELS = 150;
  localparam int FB_PIXELS   = FB_H_PIXELS * FB_V_PIXELS;
  localparam int FB_ADDR_W   = 15;
  localparam int FB_DATA_W   = 3;

  typedef logic [FB_DATA_W-1:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  localparam pixel_t CMD_HOME    = 3'b000;
  localparam pixel_t CMD_FILL    = 3'b001;
  localparam pixel_t CMD_CLR_OVR = 3'b010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_pixel_loader_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | input_sync                                                                 |
// | Multi-stage synchroniser with per-bit reset value and falling-edge detect. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module input_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_fall
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_async};
      r_prev  <= r_stage[STAGES-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];
  // High for exactly one cycle: synchronised value was 1 last cycle, 0 now.
  assign o_fall = r_prev & ~r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fb_pixel_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_pixel_loader                                                            |
// | Host strobe/data decoder driving the framebuffer write port, with fill.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_pixel_loader
  import fb_pkg::*;
#(
  parameter int H_PIXELS    = FB_H_PIXELS,
  parameter int V_PIXELS    = FB_V_PIXELS,
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_10mhz,
  input  logic              resetn,
  input  logic              strobe_n_async,
  input  logic              sel_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic              busy,
  output logic              overrun
);

  localparam int                c_PIXELS    = H_PIXELS * V_PIXELS;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_PIXELS - 1);

  // Asynchronous assert, synchronous release of the internal reset.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_10mhz or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic              w_strobe_sync;
  logic              w_event;
  logic              w_sel;
  logic [DATA_W-1:0] w_data;

  input_sync #(
    .WIDTH   (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_strobe_sync (
    .i_clk   (clk_10mhz),
    .i_rst_n (w_rst_n),
    .i_async (strobe_n_async),
    .o_sync  (w_strobe_sync),
    .o_fall  (w_event)
  );

  input_sync #(
    .WIDTH   (DATA_W + 1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_bus_sync (
    .i_clk   (clk_10mhz),
    .i_rst_n (w_rst_n),
    .i_async ({sel_async, data_async}),
    .o_sync  ({w_sel, w_data}),
    .o_fall  ()
  );

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_cursor;
  logic [DATA_W-1:0] r_fill_colour;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_overrun;

  always_ff @(posedge clk_10mhz or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_cursor      <= '0;
      r_fill_colour <= '0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_event) begin
            if (!w_sel) begin
              r_we          <= 1'b1;
              r_addr        <= r_cursor;
              r_wdata       <= w_data;
              r_fill_colour <= w_data;
              r_cursor      <= (r_cursor == c_LAST_ADDR) ? '0 : r_cursor + ADDR_W'(1);
            end else begin
              case (w_data)
                CMD_HOME: r_cursor <= '0;
                CMD_FILL: begin
                  r_state <= FILL;
                  r_busy  <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= '0;
                  r_wdata <= r_fill_colour;
                end
                CMD_CLR_OVR: r_overrun <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        FILL: begin
          // Host transfers cannot be queued behind a fill, so they are lost.
          if (w_event) r_overrun <= 1'b1;
          if (r_addr == c_LAST_ADDR) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_cursor <= '0;
          end else begin
            r_we   <= 1'b1;
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fb_we    = r_we;
  assign fb_addr  = r_addr;
  assign fb_wdata = r_wdata;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_pixel_loader                                                         |
// | Directed + random host transfers checked against a transfer-level model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fb_pixel_loader;

  // Reduced geometry keeps full fills and cursor wrap within a short run.
  localparam int H   = 20;
  localparam int V   = 15;
  localparam int PIX = H * V;
  localparam int SS  = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        strobe_n_async = 1'b1;
  logic        sel_async = 1'b0;
  logic [2:0]  data_async = 3'b000;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        busy;
  logic        overrun;

  fb_pixel_loader #(
    .H_PIXELS    (H),
    .V_PIXELS    (V),
    .ADDR_W      (15),
    .DATA_W      (3),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_10mhz      (clk),
    .resetn         (resetn),
    .strobe_n_async (strobe_n_async),
    .sel_async      (sel_async),
    .data_async     (data_async),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_wdata       (fb_wdata),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  busy_cnt = 0;
  int  busy_nowe = 0;
  int  max_addr = 0;

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      obs_q.push_back('{cyc, int'(fb_addr), int'(fb_wdata)});
      if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
    end
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && fb_we !== 1'b1) busy_nowe++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer-level reference: cursor, last colour, overrun and the fill window.
  int m_cursor = 0;
  int m_colour = 0;
  int m_ovr = 0;
  int m_fill_start = -1000000;

  task automatic model_reset();
    m_cursor = 0;
    m_colour = 0;
    m_ovr = 0;
    m_fill_start = -1000000;
  endtask

  task automatic model_event(input bit sel, input bit [2:0] d, input int fall);
    int ev;
    int wc;
    ev = fall + SS;
    wc = fall + SS + 1;
    if (ev >= m_fill_start && ev < m_fill_start + PIX) begin
      m_ovr = 1;
    end else if (!sel) begin
      exp_q.push_back('{wc, m_cursor, int'(d)});
      m_colour = int'(d);
      m_cursor = (m_cursor + 1) % PIX;
    end else begin
      case (d)
        3'd0: m_cursor = 0;
        3'd1: begin
          for (int k = 0; k < PIX; k++) exp_q.push_back('{wc + k, k, m_colour});
          m_fill_start = wc;
          m_cursor = 0;
        end
        3'd2: m_ovr = 0;
        default: ;
      endcase
    end
  endtask

  task automatic xfer(input bit sel, input bit [2:0] d, input int gap);
    @(negedge clk);
    sel_async  = sel;
    data_async = d;
    repeat (SS + 1 + gap) @(negedge clk);
    strobe_n_async = 1'b0;
    model_event(sel, d, cyc);
    repeat (SS + 1) @(negedge clk);
    strobe_n_async = 1'b1;
    repeat (SS + 1) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    chk({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s[%0d].data", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s[%0d].cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_fill_addr(input int target, input string tag);
    int n;
    n = 0;
    while (!(busy === 1'b1 && int'(fb_addr) >= target) && n < 2 * PIX) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".reached"}, (busy === 1'b1 && int'(fb_addr) >= target), 1);
  endtask

  task automatic mid_reset(input string tag);
    #13 resetn = 1'b0;
    #1;
    chk({tag, ".we"}, fb_we, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".ovr"}, overrun, 0);
    chk({tag, ".addr"}, fb_addr, 0);
    chk({tag, ".wdata"}, fb_wdata, 0);
    obs_q.delete();
    exp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit [2:0] d;
    bit       s;

    // Reset values while held and after release.
    repeat (3) @(negedge clk);
    chk("rst.we", fb_we, 0);
    chk("rst.addr", fb_addr, 0);
    chk("rst.wdata", fb_wdata, 0);
    chk("rst.busy", busy, 0);
    chk("rst.ovr", overrun, 0);
    resetn = 1'b1;
    settle(5);
    chk("rel.we", fb_we, 0);
    chk("rel.writes", obs_q.size(), 0);

    // Three pixels: single-cycle pulses, SS+1 clocks after the pin edge.
    xfer(1'b0, 3'b111, 0);
    xfer(1'b0, 3'b010, 0);
    xfer(1'b0, 3'b001, 0);
    settle(4);
    cmp_writes("pix3");

    // Cursor wrap: PIX+1 pixels starting from home.
    xfer(1'b1, 3'b000, 0);
    max_addr = 0;
    for (int i = 0; i <= PIX; i++) xfer(1'b0, 3'b100, 0);
    settle(4);
    cmp_writes("wrap");
    chk("wrap.max_addr", max_addr, PIX - 1);

    // HOME produces no write and returns the cursor to 0.
    for (int i = 0; i < 5; i++) xfer(1'b0, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    xfer(1'b1, 3'b000, 1);
    xfer(1'b0, 3'b011, 0);
    settle(4);
    cmp_writes("home");

    // Full-screen fill in the last pixel colour.
    xfer(1'b0, 3'b101, 0);
    busy_cnt = 0;
    busy_nowe = 0;
    xfer(1'b1, 3'b001, 0);
    settle(PIX + 10);
    chk("fill.busy_cycles", busy_cnt, PIX);
    chk("fill.busy_without_we", busy_nowe, 0);
    xfer(1'b0, 3'($urandom_range(0, 7)), 0);
    settle(4);
    cmp_writes("fill");

    // Transfers during a fill are dropped and set the sticky overrun.
    chk("ovr.initial", overrun, 0);
    xfer(1'b0, 3'($urandom_range(1, 7)), 0);
    xfer(1'b1, 3'b001, 0);
    xfer(1'b0, 3'($urandom_range(0, 7)), 0);
    xfer(1'b1, 3'b010, 0);
    chk("ovr.busy_during", busy, 1);
    chk("ovr.set", overrun, m_ovr);
    settle(PIX + 10);
    cmp_writes("ovr_fill");
    chk("ovr.held", overrun, m_ovr);
    xfer(1'b1, 3'b010, 0);
    chk("ovr.cleared", overrun, m_ovr);

    // Random mix of pixels, commands and reserved codes.
    for (int i = 0; i < 60; i++) begin
      s = ($urandom_range(0, 3) == 0);
      d = 3'($urandom_range(0, 7));
      xfer(s, d, $urandom_range(0, 3));
    end
    settle(PIX + 10);
    cmp_writes("rand");
    chk("rand.ovr", overrun, m_ovr);
    chk("rand.busy", busy, 0);

    // Reset mid-fill: cursor is not restored afterwards.
    for (int i = 0; i < 3; i++) xfer(1'b0, 3'($urandom_range(1, 7)), 0);
    xfer(1'b1, 3'b001, 0);
    xfer(1'b0, 3'($urandom_range(0, 7)), 0);
    wait_fill_addr(100, "rstA");
    mid_reset("rstA");
    xfer(1'b0, 3'($urandom_range(0, 7)), 0);
    settle(4);
    cmp_writes("rstA.pix");

    // Reset mid-fill: fill colour returns to 000.
    xfer(1'b0, 3'($urandom_range(1, 7)), 0);
    xfer(1'b1, 3'b001, 0);
    wait_fill_addr(50, "rstB");
    mid_reset("rstB");
    xfer(1'b1, 3'b001, 0);
    settle(PIX + 10);
    cmp_writes("rstB.fill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
